wbc_irq_arb: RTL and testbench
==============================

Name: wbc_irq_arb

Overview:
- Priority/round-robin interrupt scheduler placed in front of one channel of the vectored interrupt controller (wbc_vic).
- Takes N peripheral requests, each tagged with a bus-request level BR4..BR7, and masks them against the CPU priority (PSW[7:5]).
- Grants one winner and presents it as a single stable request + vector to the VIC channel.
- Routes the VIC acknowledge back to the winner as a one-cycle pulse, then enforces a release gap before the next grant.

Parameters:
- N, 4, number of peripheral request sources (1..16).
- HOLD, 2, length of the RELEASE gap in clocks after an acknowledge (1..15).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous active-high reset
- ireq  in  N  peripheral request lines, level-sensitive
- ivec  in  N*16  vector per source; source i uses bits [16i+15:16i]
- ilev  in  N*2  level per source; source i uses bits [2i+1:2i]; code 0..3 means BR4..BR7
- cpu_pri  in  3  current CPU priority, 0..7
- vstb_i  in  1  VIC vector-fetch strobe in progress; locks the current grant
- iack_i  in  1  acknowledge pulse from the VIC channel
- iack  out  N  one-hot acknowledge pulse to the winning peripheral
- irq_o  out  1  request to the VIC channel
- vec_o  out  16  vector of the granted source
- lev_o  out  3  effective level (4..7) of the granted source; 0 when idle

Behaviour:
- Reset (async, any state): state=IDLE, irq_o=0, vec_o=0, lev_o=0, iack=0, rr_ptr=N-1, hold counter=0.
- Eligibility: source i is eligible iff ireq[i]=1 and (4+ilev[i]) > cpu_pri. Arithmetic is done in 3 bits, unsigned.
- Selection:
  - Among eligible sources, take the highest effective level.
  - Within that level, pick the first index after rr_ptr, modulo N (wraps from N-1 to 0).
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If any source is eligible at edge t, latch win, vec_o=ivec[win], lev_o=4+ilev[win] and set irq_o=1 at t+1; go to GRANT.
  - Latency from request to irq_o is 1 clock.
- GRANT:
  - vec_o and lev_o are held constant; input changes do not alter them.
  - No preemption by higher-level requests.
  - iack_i=1 (highest priority in GRANT):
    - next cycle iack[win]=1 for exactly 1 clock, irq_o=0, rr_ptr=win;
    - go to RELEASE with the counter loaded to HOLD.
  - Withdrawal, only when vstb_i=0 and iack_i=0: if ireq[win]=0, or cpu_pri >= lev_o:
    - irq_o=0, lev_o=0, go to IDLE;
    - rr_ptr unchanged, no iack.
  - While vstb_i=1 the grant is locked: withdrawal conditions are ignored and the block waits for iack_i.
- RELEASE:
  - irq_o=0, iack=0 after the first cycle.
  - Counter decrements each clock; at 1, go to IDLE and clear lev_o.
  - Requests are not evaluated in RELEASE. This gives the peripheral HOLD clocks to drop ireq.
- Simultaneous iack_i with withdrawal conditions: the acknowledge wins.
- iack_i in IDLE or RELEASE is ignored; no iack pulse is generated.
- At most one iack bit is high in any cycle, and only in the cycle after a GRANT-state iack_i.
- Reset asserted mid-GRANT or mid-RELEASE: all outputs clear immediately (asynchronously). No pending acknowledge is replayed after reset.
- N=1: rr_ptr is fixed at 0; round-robin degenerates to a single source.

Decomposition:
- Shared package (dvk_irq_pkg):
  - BR level base constant (4);
  - level-code width (2);
  - FSM state encoding for IDLE/GRANT/RELEASE.
- One sub-module, wbc_irq_pick: combinational eligibility mask plus highest-level, rotating-priority search. Inputs: ireq, ilev, cpu_pri, rr_ptr. Outputs: valid, win index.
- Top level holds the FSM, latches, hold counter and iack pulse.

Test Plan:
- Basic grant: N=4, cpu_pri=0, ireq=0010, ilev[1]=1, ivec[1]=0o000060 -> irq_o=1 one clock later with vec_o=0o000060 and lev_o=5. Pulse iack_i -> iack=0010 for one clock, irq_o=0, irq_o stays low for HOLD=2 clocks.
- Level priority: ireq=1001, ilev[0]=3, ilev[3]=0 -> grant source 0 with lev_o=7. Set cpu_pri=4 with only source 3 requesting at BR4 -> no irq_o.
- Round-robin: ireq=0111, all at BR4, cpu_pri=0, each grant acked and each source keeping its request -> grant order 0,1,2,0, iack one-hot each time.
- Withdrawal: grant source 2 at BR5, then raise cpu_pri to 5 with vstb_i=0 -> irq_o=0 next clock, lev_o=0, no iack, rr_ptr unchanged.
- Lock and simultaneous events: grant source 1, assert vstb_i=1, drop ireq[1] -> grant held. iack_i and ireq[1]=0 in the same cycle -> iack=0010 pulse, state goes to RELEASE.
- Async reset mid-GRANT: assert wb_rst_i between clock edges -> irq_o, vec_o, lev_o, iack all 0 immediately. After release with ireq=0001 -> source 0 granted first (rr_ptr=N-1).

Source files
------------

// File: rtl/dvk_irq_pkg.sv
// ============================================================================
// Module : dvk_irq_pkg
// Brief  : Shared constants and FSM encoding for the interrupt arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dvk_irq_pkg;

    localparam logic [2:0] c_br_base = 3'd4;
    localparam int         c_lev_w   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Map a 2-bit level code onto the BR4..BR7 bus-request level.
    function automatic logic [2:0] eff_lev(input logic [c_lev_w-1:0] code);
        return c_br_base + {1'b0, code};
    endfunction

endpackage

`default_nettype wire

// File: rtl/wbc_irq_arb_if.sv
// ============================================================================
// Module : wbc_irq_arb_if
// Brief  : Peripheral-request / VIC-channel bundle for wbc_irq_arb.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wbc_irq_arb_if
    import dvk_irq_pkg::*;
#(
    parameter int N = 4
);
    logic [N-1:0]         ireq;
    logic [16*N-1:0]      ivec;
    logic [c_lev_w*N-1:0] ilev;
    logic [2:0]           cpu_pri;
    logic                 vstb_i;
    logic                 iack_i;
    logic [N-1:0]         iack;
    logic                 irq_o;
    logic [15:0]          vec_o;
    logic [2:0]           lev_o;

    modport slave (
        input  ireq, ivec, ilev, cpu_pri, vstb_i, iack_i,
        output iack, irq_o, vec_o, lev_o
    );

    modport master (
        output ireq, ivec, ilev, cpu_pri, vstb_i, iack_i,
        input  iack, irq_o, vec_o, lev_o
    );
endinterface

`default_nettype wire

// File: rtl/wbc_irq_pick.sv
// ============================================================================
// Module : wbc_irq_pick
// Brief  : Eligibility mask plus highest-level, rotating-priority winner search.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wbc_irq_pick
    import dvk_irq_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]         ireq,
    input  wire logic [c_lev_w*N-1:0] ilev,
    input  wire logic [2:0]           cpu_pri,
    input  wire logic [PW-1:0]        rr_ptr,
    output logic                      valid,
    output logic [PW-1:0]             win
);

    logic [2:0]    w_lev [N];
    logic [N-1:0]  w_elig;
    logic [2:0]    w_top;
    logic [PW-1:0] w_idx;

    always_comb begin
        w_elig = '0;
        w_top  = '0;
        for (int i = 0; i < N; i++) begin
            w_lev[i] = eff_lev(ilev[c_lev_w*i +: c_lev_w]);
            if (ireq[i] && (w_lev[i] > cpu_pri)) begin
                w_elig[i] = 1'b1;
                if (w_lev[i] > w_top)
                    w_top = w_lev[i];
            end
        end
    end

    // Scan starts one past the last acknowledged source so ties rotate.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        w_idx = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = PW'((int'(rr_ptr) + k) % N);
            if (!valid && w_elig[w_idx] && (w_lev[w_idx] == w_top)) begin
                valid = 1'b1;
                win   = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wbc_irq_arb.sv
// ============================================================================
// Module : wbc_irq_arb
// Brief  : Priority/round-robin interrupt scheduler feeding one VIC channel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wbc_irq_arb
    import dvk_irq_pkg::*;
#(
    parameter int N    = 4,
    parameter int HOLD = 2
) (
    input  wire logic     wb_clk_i,
    input  wire logic     wb_rst_i,
    wbc_irq_arb_if.slave  bus
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_win, w_win_nxt;
    logic [PW-1:0] r_rr_ptr, w_rr_nxt;
    logic [15:0]   r_vec, w_vec_nxt;
    logic [2:0]    r_lev, w_lev_nxt;
    logic          r_irq, w_irq_nxt;
    logic [N-1:0]  r_iack, w_iack_nxt;
    logic [3:0]    r_hold, w_hold_nxt;
    logic          w_pick_valid;
    logic [PW-1:0] w_pick_win;

    wbc_irq_pick #(.N(N), .PW(PW)) u_pick (
        .ireq    (bus.ireq),
        .ilev    (bus.ilev),
        .cpu_pri (bus.cpu_pri),
        .rr_ptr  (r_rr_ptr),
        .valid   (w_pick_valid),
        .win     (w_pick_win)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state  <= ST_IDLE;
            r_win    <= '0;
            r_rr_ptr <= PW'(N - 1);
            r_vec    <= '0;
            r_lev    <= '0;
            r_irq    <= 1'b0;
            r_iack   <= '0;
            r_hold   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_win    <= w_win_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_vec    <= w_vec_nxt;
            r_lev    <= w_lev_nxt;
            r_irq    <= w_irq_nxt;
            r_iack   <= w_iack_nxt;
            r_hold   <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win;
        w_rr_nxt    = r_rr_ptr;
        w_vec_nxt   = r_vec;
        w_lev_nxt   = r_lev;
        w_irq_nxt   = r_irq;
        w_iack_nxt  = '0;
        w_hold_nxt  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_win_nxt   = w_pick_win;
                    w_irq_nxt   = 1'b1;
                    w_state_nxt = ST_GRANT;
                    for (int i = 0; i < N; i++) begin
                        if (w_pick_win == PW'(i)) begin
                            w_vec_nxt = bus.ivec[16*i +: 16];
                            w_lev_nxt = eff_lev(bus.ilev[c_lev_w*i +: c_lev_w]);
                        end
                    end
                end
            end
            ST_GRANT: begin
                // Acknowledge outranks withdrawal; vstb_i only blocks withdrawal.
                if (bus.iack_i) begin
                    w_iack_nxt  = N'(1) << r_win;
                    w_irq_nxt   = 1'b0;
                    w_rr_nxt    = r_win;
                    w_hold_nxt  = 4'(HOLD);
                    w_state_nxt = ST_RELEASE;
                end else if (!bus.vstb_i &&
                             (!bus.ireq[r_win] || (bus.cpu_pri >= r_lev))) begin
                    w_irq_nxt   = 1'b0;
                    w_lev_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                w_hold_nxt = r_hold - 4'd1;
                if (r_hold <= 4'd1) begin
                    w_lev_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.irq_o = r_irq;
    assign bus.vec_o = r_vec;
    assign bus.lev_o = r_lev;
    assign bus.iack  = r_iack;

endmodule

`default_nettype wire

// File: tb/tb_wbc_irq_arb.sv
// ============================================================================
// Module : tb_wbc_irq_arb
// Brief  : Self-checking bench for wbc_irq_arb (vector table + hand sequences).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wbc_irq_arb;
    localparam int N    = 4;
    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wbc_irq_arb_if #(.N(N)) bus();

    wbc_irq_arb #(.N(N), .HOLD(HOLD)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    typedef struct {
        logic [3:0]  ireq;
        logic [7:0]  ilev;
        logic [2:0]  pri;
        logic        irq;
        logic [15:0] vec;
        logic [2:0]  lev;
    } vec_t;

    typedef struct {
        logic        irq;
        logic [15:0] vec;
        logic [2:0]  lev;
    } exp_t;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    int   src_q[$];
    vec_t tbl[8];

    function automatic logic [15:0] vof(input int i);
        return 16'o50 + 16'(8 * i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_vec++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, ex);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic ack();
        bus.iack_i = 1'b1;
        step();
        bus.iack_i = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   s;
        bus.ireq    = '0;
        bus.ilev    = '0;
        bus.cpu_pri = '0;
        bus.vstb_i  = 1'b0;
        bus.iack_i  = 1'b0;
        for (int i = 0; i < N; i++) bus.ivec[16*i +: 16] = vof(i);

        step();
        chk("rst_irq", 32'(bus.irq_o), 0);
        chk("rst_vec", 32'(bus.vec_o), 0);
        chk("rst_lev", 32'(bus.lev_o), 0);
        chk("rst_iack", 32'(bus.iack), 0);
        rst = 1'b0;
        step();

        // ilev packing is {l3,l2,l1,l0}
        tbl[0] = '{4'b0010, 8'b0000_0100, 3'd0, 1'b1, 16'o60,  3'd5};
        tbl[1] = '{4'b1001, 8'b0000_0011, 3'd0, 1'b1, 16'o50,  3'd7};
        tbl[2] = '{4'b1000, 8'b0000_0000, 3'd4, 1'b0, 16'o0,   3'd0};
        tbl[3] = '{4'b1000, 8'b0000_0000, 3'd3, 1'b1, 16'o100, 3'd4};
        tbl[4] = '{4'b1111, 8'b1010_0100, 3'd0, 1'b1, 16'o70,  3'd6};
        tbl[5] = '{4'b0110, 8'b0011_1100, 3'd6, 1'b1, 16'o60,  3'd7};
        tbl[6] = '{4'b1111, 8'b1111_1111, 3'd7, 1'b0, 16'o0,   3'd0};
        tbl[7] = '{4'b0000, 8'b1111_1111, 3'd0, 1'b0, 16'o0,   3'd0};

        for (int v = 0; v < 8; v++) begin
            bus.ireq    = tbl[v].ireq;
            bus.ilev    = tbl[v].ilev;
            bus.cpu_pri = tbl[v].pri;
            exp_q.push_back('{tbl[v].irq, tbl[v].vec, tbl[v].lev});
            step();
            e = exp_q.pop_front();
            chk($sformatf("tbl%0d_irq", v), 32'(bus.irq_o), 32'(e.irq));
            chk($sformatf("tbl%0d_lev", v), 32'(bus.lev_o), 32'(e.lev));
            if (e.irq) chk($sformatf("tbl%0d_vec", v), 32'(bus.vec_o), 32'(e.vec));
            bus.ireq = '0;
            step();
            chk($sformatf("tbl%0d_wd_irq", v), 32'(bus.irq_o), 0);
            chk($sformatf("tbl%0d_wd_lev", v), 32'(bus.lev_o), 0);
            step();
        end
        bus.cpu_pri = '0;

        // Basic grant, acknowledge pulse and release gap
        do_reset();
        bus.ilev = 8'b0000_0100;
        bus.ireq = 4'b0010;
        step();
        chk("basic_irq", 32'(bus.irq_o), 1);
        chk("basic_vec", 32'(bus.vec_o), 32'(16'o60));
        chk("basic_lev", 32'(bus.lev_o), 5);
        ack();
        chk("basic_iack", 32'(bus.iack), 32'(4'b0010));
        chk("basic_ack_irq", 32'(bus.irq_o), 0);
        step();
        chk("basic_iack_1clk", 32'(bus.iack), 0);
        chk("basic_gap1_irq", 32'(bus.irq_o), 0);
        step();
        chk("basic_gap2_irq", 32'(bus.irq_o), 0);
        step();
        chk("basic_regrant_irq", 32'(bus.irq_o), 1);
        bus.ireq = '0;
        step();

        // Round-robin among three BR4 sources that keep requesting
        do_reset();
        bus.ilev = '0;
        bus.ireq = 4'b0111;
        src_q.push_back(0);
        src_q.push_back(1);
        src_q.push_back(2);
        src_q.push_back(0);
        while (src_q.size() > 0) begin
            s = src_q.pop_front();
            for (int t = 0; t < 10 && !bus.irq_o; t++) step();
            chk("rr_irq", 32'(bus.irq_o), 1);
            chk("rr_vec", 32'(bus.vec_o), 32'(vof(s)));
            ack();
            chk("rr_iack", 32'(bus.iack), 32'd1 << s);
        end
        bus.ireq = '0;
        step();
        step();
        step();

        // Withdrawal by CPU priority; rr_ptr must stay put
        do_reset();
        bus.ilev = 8'b0001_0000;
        bus.ireq = 4'b0100;
        step();
        chk("wd_grant_vec", 32'(bus.vec_o), 32'(16'o70));
        bus.cpu_pri = 3'd5;
        step();
        chk("wd_irq", 32'(bus.irq_o), 0);
        chk("wd_lev", 32'(bus.lev_o), 0);
        chk("wd_iack", 32'(bus.iack), 0);
        bus.cpu_pri = 3'd0;
        bus.ilev    = 8'b0101_0000;
        bus.ireq    = 4'b1100;
        step();
        chk("wd_ptr_irq", 32'(bus.irq_o), 1);
        chk("wd_ptr_vec", 32'(bus.vec_o), 32'(16'o70));
        bus.ireq = '0;
        step();
        step();

        // Grant lock under vstb_i, then ack coinciding with withdrawal
        do_reset();
        bus.ilev = '0;
        bus.ireq = 4'b0010;
        step();
        chk("lock_vec", 32'(bus.vec_o), 32'(16'o60));
        bus.vstb_i = 1'b1;
        bus.ireq   = '0;
        step();
        step();
        chk("lock_irq_held", 32'(bus.irq_o), 1);
        chk("lock_vec_held", 32'(bus.vec_o), 32'(16'o60));
        bus.vstb_i = 1'b0;
        ack();
        chk("sim_iack", 32'(bus.iack), 32'(4'b0010));
        chk("sim_irq", 32'(bus.irq_o), 0);
        ack();
        chk("rel_ack_ignored", 32'(bus.iack), 0);
        step();
        step();
        ack();
        chk("idle_ack_ignored", 32'(bus.iack), 0);
        chk("idle_irq", 32'(bus.irq_o), 0);

        // Asynchronous reset mid-GRANT
        do_reset();
        bus.ireq = 4'b0100;
        step();
        chk("ar_pre_irq", 32'(bus.irq_o), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_irq", 32'(bus.irq_o), 0);
        chk("ar_vec", 32'(bus.vec_o), 0);
        chk("ar_lev", 32'(bus.lev_o), 0);
        chk("ar_iack", 32'(bus.iack), 0);
        bus.ireq = 4'b1001;
        step();
        rst = 1'b0;
        step();
        chk("ar_post_irq", 32'(bus.irq_o), 1);
        chk("ar_post_vec", 32'(bus.vec_o), 32'(16'o50));
        chk("ar_post_lev", 32'(bus.lev_o), 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
